// File: rtl/mux_pkg.sv
// Shared definitions for the datapath word multiplexers: default widths and a
// constant-foldable ceiling log2 used to size select ports.
package mux_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 8;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_n_sel.sv
// Combinational NUM_IN:1 word selector; out-of-range selects yield zero and
// raise range_err.
module mux_n_sel
  import mux_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = clog2(NUM_IN)
) (
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] din,
  output logic [WIDTH-1:0]        word,
  output logic                    range_err
);

  always_comb begin
    word      = '0;
    range_err = (int'(sel) >= NUM_IN);
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(sel) == k) begin
        word = din[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/mux_n_reg.sv
// Registered N:1 word multiplexer with valid/ready handshake, out-of-range
// select flag and a sticky saturating select-error counter.
module mux_n_reg
  import mux_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = clog2(NUM_IN),
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] din,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        dout,
  output logic                    sel_err,
  input  logic                    err_clr,
  output logic [CNT_W-1:0]        err_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [WIDTH-1:0] word_p0;
  logic             range_err_p0;
  logic             accept;

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic             err_p1;
  logic [CNT_W-1:0] cnt_p1;

  // Stage p0: combinational selection from the upstream word set.
  mux_n_sel #(
    .WIDTH (WIDTH),
    .NUM_IN(NUM_IN),
    .SEL_W (SEL_W)
  ) u_sel (
    .sel      (sel),
    .din      (din),
    .word     (word_p0),
    .range_err(range_err_p0)
  );

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;

  // Stage p1: output register; a held word stays put until drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      err_p1  <= 1'b0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= word_p0;
      err_p1  <= range_err_p0;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  // A clear coinciding with an erroring accept keeps that error counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1 <= '0;
    end else if (err_clr) begin
      cnt_p1 <= (accept && range_err_p0) ? CNT_W'(1) : '0;
    end else if (accept && range_err_p0) begin
      cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign out_valid = vld_p1;
  assign dout      = data_p1;
  assign sel_err   = err_p1;
  assign err_cnt   = cnt_p1;

endmodule
